// File: rtl/span_cme.sv
// span_cme: memory-mapped SPAN helper computing price scan range and scan risk
module span_cme #(
    parameter int DIVISOR = 100,
    parameter int LATENCY = 34
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [4:0]  offset,
    input  logic [15:0] writeData,
    output logic [15:0] readData,
    output logic [15:0] PriceScanRange
);
    localparam int RW = $clog2(DIVISOR);
    localparam logic [RW:0] DV = DIVISOR[RW:0];

    typedef enum logic [1:0] {IDLE, MUL, DIV, RISK} state_t;

    logic [15:0]   regs_q [0:28];
    state_t        state_q, state_d;
    logic [15:0]   p_q, s_q, q_q, d_q, p_d, s_d, q_d, d_d;
    logic [31:0]   quo_q, quo_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [15:0]   psr_q, psr_d, risk_q, risk_d;
    logic          wr, launch;
    logic [RW:0]   sh;
    logic signed [31:0] qd;
    logic [31:0]   mag;
    logic [15:0]   psr_w;
    logic [47:0]   risk_w;
    logic [15:0]   rd_mux;

    assign wr     = chipselect & write;
    assign launch = wr && offset == 5'd28;
    assign sh     = {rem_q, quo_q[31]};
    assign qd     = 32'($signed(q_q)) * 32'($signed(d_q));
    assign mag    = qd[31] ? -qd : qd;
    assign psr_w  = |quo_q[31:16] ? 16'hFFFF : quo_q[15:0];
    assign risk_w = 48'(mag) * 48'(psr_w);
    assign rd_mux = offset <= 5'd28 ? regs_q[offset] :
                    offset == 5'd29 ? {14'd0, done_q, busy_q} :
                    offset == 5'd30 ? psr_q : risk_q;
    assign PriceScanRange = psr_q;

    // Host register file writes and registered reads (reads see pre-write data)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 29; i++) regs_q[i] <= '0;
            readData <= '0;
        end else begin
            if (wr && offset <= 5'd28) regs_q[offset] <= writeData;
            if (chipselect && read) readData <= rd_mux;
        end
    end

    // Calculation state and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            {p_q, s_q, q_q, d_q} <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            psr_q   <= '0;
            risk_q  <= '0;
        end else begin
            state_q <= state_d;
            {p_q, s_q, q_q, d_q} <= {p_d, s_d, q_d, d_d};
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            psr_q   <= psr_d;
            risk_q  <= risk_d;
        end
    end

    // Launch snapshot, multiply, restoring divide, then risk and result publish
    always_comb begin
        state_d = state_q;
        {p_d, s_d, q_d, d_d} = {p_q, s_q, q_q, d_q};
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        psr_d   = psr_q;
        risk_d  = risk_q;
        if (launch) begin
            state_d = MUL;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            {p_d, s_d, q_d, d_d} = {regs_q[0], regs_q[1], regs_q[2], regs_q[3]};
        end else begin
            case (state_q)
                MUL: begin
                    quo_d   = 32'(p_q) * 32'(s_q);
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end
                DIV: begin
                    rem_d   = sh >= DV ? RW'(sh - DV) : sh[RW-1:0];
                    quo_d   = {quo_q[30:0], sh >= DV};
                    cnt_d   = cnt_q + 5'd1;
                    state_d = cnt_q == 5'(LATENCY - 3) ? RISK : DIV;
                end
                RISK: begin
                    psr_d   = psr_w;
                    risk_d  = |risk_w[47:16] ? 16'hFFFF : risk_w[15:0];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_span_cme.sv
// tb_span_cme: table-driven and randomized checks of span_cme against an arithmetic model
module tb_span_cme;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
    logic [4:0]  offset = '0;
    logic [15:0] writeData = '0;
    logic [15:0] readData, PriceScanRange;

    int n_pass = 0, n_total = 0;
    logic [15:0] last_psr = '0;

    typedef struct {
        logic [15:0] p, s, q, d, psr, risk;
    } vec_t;

    span_cme dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .read(read), .offset(offset), .writeData(writeData),
        .readData(readData), .PriceScanRange(PriceScanRange)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    task automatic wr(input logic [4:0] o, input logic [15:0] v, input logic cs);
        chipselect = cs; write = 1'b1; offset = o; writeData = v;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] o, output logic [15:0] v);
        chipselect = 1'b1; read = 1'b1; offset = o;
        @(negedge clk);
        v = readData;
        chipselect = 1'b0; read = 1'b0;
    endtask

    function automatic void model(input logic [15:0] p, s, q, d, output logic [15:0] psr, risk);
        longint quo, pv, m, r;
        quo = (longint'(p) * longint'(s)) / 100;
        pv  = quo > 65535 ? 65535 : quo;
        m   = longint'($signed(q)) * longint'($signed(d));
        if (m < 0) m = -m;
        r    = m * pv;
        psr  = 16'(pv);
        risk = r > 65535 ? 16'hFFFF : 16'(r);
    endfunction

    // launch via R28, then check busy, exact result latency, and final reads
    task automatic launch_check(input logic [15:0] ep, input logic [15:0] er);
        logic [15:0] v;
        wr(5'd28, 16'h00AA, 1'b1);
        rd(5'd29, v);
        chk("status_busy", v, 16'h0001);
        repeat (32) @(negedge clk);
        chk("psr_hold", PriceScanRange, last_psr);
        @(negedge clk);
        chk("psr", PriceScanRange, ep);
        rd(5'd31, v);
        chk("risk", v, er);
        rd(5'd30, v);
        chk("psr_rd", v, ep);
        rd(5'd29, v);
        chk("status_done", v, 16'h0002);
        last_psr = ep;
    endtask

    task automatic go(input logic [15:0] p, s, q, d, ep, er);
        wr(5'd0, p, 1'b1);
        wr(5'd1, s, 1'b1);
        wr(5'd2, q, 1'b1);
        wr(5'd3, d, 1'b1);
        launch_check(ep, er);
    endtask

    initial begin
        logic [15:0] tp [0:28];
        vec_t vt [8];
        logic [15:0] v, ep, er, p, s, q, d;

        for (int i = 0; i < 29; i++) tp[i] = '0;
        tp[0] = 16'd96; tp[1] = 16'd10; tp[2] = 16'd15; tp[3] = 16'hFFFB;
        tp[9] = 16'd3; tp[10] = 16'd1; tp[11] = 16'd5;
        tp[17] = 16'd2; tp[18] = 16'd4; tp[19] = 16'd6;
        for (int i = 0; i < 9; i++) tp[20 + i] = 16'(50 + 10 * i - (i >= 6 ? 10 : 0));

        vt[0] = '{16'd1000,  16'd7,     16'hFFFD, 16'd4,    16'd70,    16'd840};
        vt[1] = '{16'd65535, 16'd200,   16'hFFFD, 16'd4,    16'hFFFF,  16'hFFFF};
        vt[2] = '{16'd0,     16'd50,    16'd5,    16'd5,    16'd0,     16'd0};
        vt[3] = '{16'd500,   16'd0,     16'd5,    16'd5,    16'd0,     16'd0};
        vt[4] = '{16'd96,    16'd10,    16'h8000, 16'h8000, 16'd9,     16'hFFFF};
        vt[5] = '{16'd100,   16'd1,     16'h8000, 16'd1,    16'd1,     16'd32768};
        vt[6] = '{16'd199,   16'd1,     16'd2,    16'd3,    16'd1,     16'd6};
        vt[7] = '{16'd65535, 16'd100,   16'd1,    16'd1,    16'd65535, 16'd65535};

        repeat (2) @(negedge clk);
        chk("rst_psr", PriceScanRange, 16'd0);
        chk("rst_rdata", readData, 16'd0);
        reset = 1'b0;
        @(negedge clk);
        rd(5'd29, v);
        chk("rst_status", v, 16'd0);

        for (int i = 0; i < 28; i++) wr(5'(i), tp[i], 1'b1);
        chipselect = 1'b1; write = 1'b1; offset = 5'd28; writeData = tp[28];
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        rd(5'd29, v);
        chk("plan_busy", v, 16'h0001);
        repeat (32) @(negedge clk);
        chk("plan_hold", PriceScanRange, 16'd0);
        @(negedge clk);
        chk("plan_psr", PriceScanRange, 16'd9);
        rd(5'd31, v);
        chk("plan_risk", v, 16'd675);
        rd(5'd29, v);
        chk("plan_status", v, 16'h0002);
        last_psr = 16'd9;

        for (int i = 0; i < 29; i++) begin
            rd(5'(i), v);
            chk($sformatf("readback_%0d", i), v, tp[i]);
        end

        chipselect = 1'b1; read = 1'b1; write = 1'b1; offset = 5'd9; writeData = 16'h1234;
        @(negedge clk);
        v = readData;
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        chk("rw_same_cycle", v, 16'd3);
        rd(5'd9, v);
        chk("rw_after", v, 16'h1234);

        for (int i = 0; i < 8; i++) go(vt[i].p, vt[i].s, vt[i].q, vt[i].d, vt[i].psr, vt[i].risk);

        for (int i = 0; i < 20; i++) begin
            p = 16'($urandom);
            s = (i % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
            q = (i % 2 == 0) ? 16'($urandom) : 16'($signed(16'($urandom_range(0, 40))) - 16'sd20);
            d = (i % 4 == 1) ? 16'($urandom) : 16'($signed(16'($urandom_range(0, 20))) - 16'sd10);
            model(p, s, q, d, ep, er);
            go(p, s, q, d, ep, er);
        end

        go(16'd1000, 16'd7, 16'hFFFD, 16'd4, 16'd70, 16'd840);
        wr(5'd0, 16'd96, 1'b1);
        wr(5'd1, 16'd10, 1'b1);
        wr(5'd2, 16'd15, 1'b1);
        wr(5'd3, 16'hFFFB, 1'b1);
        wr(5'd28, 16'd1, 1'b1);
        repeat (8) @(negedge clk);
        wr(5'd1, 16'd20, 1'b1);
        wr(5'd28, 16'd2, 1'b1);
        repeat (23) @(negedge clk);
        @(negedge clk);
        chk("relaunch_no_first", PriceScanRange, 16'd70);
        repeat (9) @(negedge clk);
        chk("relaunch_hold", PriceScanRange, 16'd70);
        @(negedge clk);
        chk("relaunch_psr", PriceScanRange, 16'd19);
        rd(5'd31, v);
        chk("relaunch_risk", v, 16'd1425);
        rd(5'd29, v);
        chk("relaunch_status", v, 16'h0002);

        wr(5'd1, 16'd7, 1'b1);
        wr(5'd28, 16'd3, 1'b1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_psr", PriceScanRange, 16'd0);
        chk("midrst_rdata", readData, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        rd(5'd29, v);
        chk("midrst_status", v, 16'd0);
        repeat (40) @(negedge clk);
        chk("midrst_no_result", PriceScanRange, 16'd0);
        rd(5'd31, v);
        chk("midrst_risk", v, 16'd0);
        rd(5'd0, v);
        chk("midrst_r0", v, 16'd0);
        last_psr = 16'd0;

        go(16'd1000, 16'd7, 16'hFFFD, 16'd4, 16'd70, 16'd840);
        wr(5'd0, 16'd5, 1'b0);
        wr(5'd28, 16'd5, 1'b0);
        wr(5'd29, 16'hABCD, 1'b1);
        wr(5'd30, 16'hABCD, 1'b1);
        wr(5'd31, 16'hABCD, 1'b1);
        repeat (3) @(negedge clk);
        rd(5'd0, v);
        chk("ign_r0", v, 16'd1000);
        rd(5'd28, v);
        chk("ign_r28", v, 16'h00AA);
        rd(5'd29, v);
        chk("ign_status", v, 16'h0002);
        rd(5'd30, v);
        chk("ign_psr_rd", v, 16'd70);
        rd(5'd31, v);
        chk("ign_risk", v, 16'd840);
        chk("ign_psr", PriceScanRange, 16'd70);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
